// File: rtl/fp_expand_seq.sv
// Rebuilds the integer value (-1)^S * F * 2^E of a packed {S, E, F} float as an
// OUT_W-bit two's complement word, using one left shift per clock.
module fp_expand_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5,
  parameter int OUT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [EXP_W-1:0] in_e,
  input  logic [MAN_W-1:0] in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_d,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SIGN,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic               r_s;
  logic [OUT_W-2:0]   r_mag;
  logic [EXP_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_d;
  logic               r_out_zero;
  logic               r_busy;

  logic [OUT_W-2:0]   w_f_ext;
  logic [OUT_W-1:0]   w_mag_ext;
  logic [OUT_W-1:0]   w_signed;

  // The magnitude keeps one spare top bit so the negated value can never wrap.
  assign w_f_ext   = {{(OUT_W-1-MAN_W){1'b0}}, in_f};
  assign w_mag_ext = {1'b0, r_mag};
  assign w_signed  = r_s ? (~w_mag_ext + 1'b1) : w_mag_ext;

  // NOTE: every state register is written with <= so all of them update from
  // the same pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s         <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_d     <= '0;
      r_out_zero  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_s        <= in_s;
            r_mag      <= w_f_ext;
            r_cnt      <= in_e;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= (in_e != '0) ? ST_SHIFT : ST_SIGN;
          end
        end
        ST_SHIFT: begin
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == EXP_W'(1)) begin
            r_state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          r_out_d     <= w_signed;
          r_out_zero  <= (r_mag == '0);
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          // out_d and out_zero are untouched here, so they hold under backpressure.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_d     = r_out_d;
  assign out_zero  = r_out_zero;
  assign busy      = r_busy;

endmodule
